// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage's req/gnt/rvalid protocol.
// Requests are granted while fewer than two are pending. The responder answers
// them in order from an internal word-addressed memory. Each answer waits
// WAIT_STATES extra cycles at the head of the pending queue. A side load port
// preloads or patches memory at any time.
//
// Parameters
//   ADDR_WIDTH  : word-index width; the memory holds 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES : extra cycles each response waits at the queue head (0..7)
//
// Ports
//   req              in   clock (rising edge)
//   reset            in   synchronous, active-high reset
//   instr_req_in     in   fetch requests a word
//   instr_addr_in    in   byte address of the request
//   gnt_out          out  request accepted at this edge (combinational)
//   instr_rvalid_out out  one-cycle response strobe per accepted request
//   instr_rdata_out  out  instruction word; holds its value between responses
//   err_out          out  response is for an illegal address (only with rvalid)
//   load_we_in       in   preload write enable
//   load_addr_in     in   preload byte address (word index = [ADDR_WIDTH+1:2])
//   load_data_in     in   preload write data
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        req,
  input  logic        reset,
  input  logic        instr_req_in,
  input  logic [31:0] instr_addr_in,
  output logic        gnt_out,
  output logic        instr_rvalid_out,
  output logic [31:0] instr_rdata_out,
  output logic        err_out,
  input  logic        load_we_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // Head state machine and pending queue
  state_t                r_state;
  logic [2:0]            r_wcnt;
  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_q_idx [2];
  logic                  r_q_err [2];

  // Storage
  logic [31:0]           r_mem [DEPTH];

  // Registered response outputs
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic                  r_err;

  // Request decode
  logic                  w_gnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_req_illegal;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic [31:0]           w_req_hi;

  // Load decode
  logic [31:0]           w_load_word;
  logic [ADDR_WIDTH-1:0] w_load_idx;
  logic                  w_load_ok;

  // Queue head
  logic [ADDR_WIDTH-1:0] w_head_idx;
  logic                  w_head_err;
  logic [31:0]           w_head_data;
  logic [1:0]            w_count_next;

  // ---------------------------------------------------------------------------
  // Grant / request decode
  // ---------------------------------------------------------------------------
  // The grant looks only at the count before the edge. A pop at the same
  // edge does not open a slot for that edge's request.
  always_comb begin
    w_gnt         = instr_req_in && !reset && (r_count < 2'd2);
    w_push        = w_gnt;
    w_req_idx     = instr_addr_in[ADDR_WIDTH+1:2];
    w_req_hi      = instr_addr_in >> (ADDR_WIDTH + 2);
    w_req_illegal = (instr_addr_in[1:0] != 2'b00) || (w_req_hi != '0);
  end

  assign gnt_out = w_gnt;

  // ---------------------------------------------------------------------------
  // Load port decode: the byte offset is ignored. Addresses above the memory
  // range are dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load_word = load_addr_in >> 2;
    w_load_idx  = w_load_word[ADDR_WIDTH-1:0];
    w_load_ok   = ((w_load_word >> ADDR_WIDTH) == '0);
  end

  // Memory is deliberately not touched by reset so that preloaded programs
  // survive a core reset.
  always_ff @(posedge req) begin
    if (load_we_in && w_load_ok) begin
      r_mem[w_load_idx] <= load_data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue head
  // ---------------------------------------------------------------------------
  // The head word is read combinationally and captured at the pop edge. A load
  // to the same word at that edge therefore lands after the read, and the
  // response carries the old contents.
  always_comb begin
    w_head_idx   = r_q_idx[r_rd_ptr];
    w_head_err   = r_q_err[r_rd_ptr];
    w_head_data  = r_mem[w_head_idx];
    w_pop        = (r_state == S_WAIT) && (r_wcnt == 3'd0);
    w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // ---------------------------------------------------------------------------
  // Queue, head FSM and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge req) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      // Pushes never overwrite the head. A push only happens with count < 2,
      // so when a push and a pop share an edge, the write slot differs from
      // the slot being read.
      if (w_push) begin
        r_q_idx[r_wr_ptr] <= w_req_idx;
        r_q_err[r_wr_ptr] <= w_req_illegal;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_rdata  <= w_head_err ? NOP : w_head_data;
      end
      r_count  <= w_count_next;
      r_rvalid <= w_pop;
      // err_out is only asserted alongside rvalid. rdata keeps its last value.
      r_err    <= w_pop && w_head_err;

      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_WAIT;
            r_wcnt  <= WS;
          end
        end
        S_WAIT: begin
          if (r_wcnt == 3'd0) begin
            // A push at the pop edge counts toward "non-empty", so the next
            // entry starts its wait immediately.
            if (w_count_next != 2'd0) begin
              r_state <= S_WAIT;
              r_wcnt  <= WS;
            end else begin
              r_state <= S_IDLE;
              r_wcnt  <= '0;
            end
          end else begin
            r_wcnt <= r_wcnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  assign instr_rvalid_out = r_rvalid;
  assign instr_rdata_out  = r_rdata;
  assign err_out          = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Three responders (WAIT_STATES = 0, 2, 3) share one stimulus stream. For each
// grant the reference model works out when the response must appear, using
// timestamps:
//   pop edge = max(grant edge, previous pop edge) + W + 1
// It pushes the expected entry into a scoreboard. The response data is fixed
// from the memory model at that pop edge. A separate monitor checks each DUT
// output cycle against the scoreboard.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam int          NDUT = 3;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    int          dut;
    int unsigned idx;
    bit          err;
    int          pop_edge;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        req_in;
  logic [31:0] addr_in;
  logic        lwe;
  logic [31:0] laddr;
  logic [31:0] ldata;

  logic [NDUT-1:0] gnt;
  logic [NDUT-1:0] rv;
  logic [NDUT-1:0] er;
  logic [31:0]     rd [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    imem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_STATES(g == 0 ? 0 : g + 1)
    ) u_dut (
      .req             (clk),
      .reset           (reset),
      .instr_req_in    (req_in),
      .instr_addr_in   (addr_in),
      .gnt_out         (gnt[g]),
      .instr_rvalid_out(rv[g]),
      .instr_rdata_out (rd[g]),
      .err_out         (er[g]),
      .load_we_in      (lwe),
      .load_addr_in    (laddr),
      .load_data_in    (ldata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [31:0] mem [1024];
  ent_t        sb [$];
  int          last_pop [NDUT];
  logic [31:0] last_rd  [NDUT];
  int          edge_n;
  bit          mon_en;
  int          checks;
  int          failures;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  // Requests still pending at the upcoming edge (popped at or after it).
  function automatic int pending(input int d, input int next_edge);
    int n;
    n = 0;
    foreach (sb[i]) if (sb[i].dut == d && sb[i].pop_edge >= next_edge) n++;
    return n;
  endfunction

  task automatic step(input bit rst, input bit rq, input logic [31:0] a,
                      input bit we, input logic [31:0] la, input logic [31:0] ld);
    bit exp_g [NDUT];
    int p;
    @(negedge clk);
    reset   = rst;
    req_in  = rq;
    addr_in = a;
    lwe     = we;
    laddr   = la;
    ldata   = ld;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      exp_g[d] = rq && !rst && (pending(d, edge_n + 1) < 2);
      checks++;
      if (gnt[d] !== exp_g[d]) begin
        failures++;
        $display("FAIL gnt dut=%0d edge=%0d got=%0b exp=%0b", d, edge_n + 1, gnt[d], exp_g[d]);
      end
    end
    @(posedge clk);
    edge_n++;
    if (rst) begin
      sb.delete();
      for (int d = 0; d < NDUT; d++) begin
        last_pop[d] = 0;
        last_rd[d]  = '0;
      end
    end else begin
      // Responses leaving at this edge see memory before this edge's load.
      foreach (sb[i])
        if (sb[i].pop_edge == edge_n)
          sb[i].data = sb[i].err ? NOP : mem[sb[i].idx];
      for (int d = 0; d < NDUT; d++) begin
        if (exp_g[d]) begin
          p = ((edge_n > last_pop[d]) ? edge_n : last_pop[d]) + wait_of(d) + 1;
          last_pop[d] = p;
          sb.push_back('{dut: d, idx: (a >> 2) % 1024,
                         err: (a % 4 != 0) || (a >= 32'd4096),
                         pop_edge: p, data: '0});
        end
      end
    end
    if (we && la < 32'd4096) mem[la >> 2] = ld;
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: compares every DUT output cycle against the scoreboard.
  always begin
    int  fi;
    bit  exp_rv;
    @(posedge clk);
    #1;
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        fi = -1;
        foreach (sb[i]) if (fi < 0 && sb[i].dut == d) fi = i;
        exp_rv = (fi >= 0) && (sb[fi].pop_edge == edge_n);
        checks++;
        if (rv[d] !== exp_rv) begin
          failures++;
          $display("FAIL rvalid dut=%0d edge=%0d got=%0b exp=%0b", d, edge_n, rv[d], exp_rv);
        end
        if (exp_rv) begin
          if (rv[d] === 1'b1) begin
            checks += 2;
            if (rd[d] !== sb[fi].data) begin
              failures++;
              $display("FAIL rdata dut=%0d edge=%0d got=%08h exp=%08h", d, edge_n, rd[d], sb[fi].data);
            end
            if (er[d] !== sb[fi].err) begin
              failures++;
              $display("FAIL err dut=%0d edge=%0d got=%0b exp=%0b", d, edge_n, er[d], sb[fi].err);
            end
          end
          last_rd[d] = sb[fi].data;
          sb.delete(fi);
        end else if (rv[d] !== 1'b1) begin
          checks++;
          if (er[d] !== 1'b0 || rd[d] !== last_rd[d]) begin
            failures++;
            $display("FAIL idle_hold dut=%0d edge=%0d got rdata=%08h err=%0b exp rdata=%08h err=0",
                     d, edge_n, rd[d], er[d], last_rd[d]);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a, la, ld;
    bit rq, we, rst;
    int r;
    checks   = 0;
    failures = 0;
    edge_n   = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    req_in   = 1'b0;
    addr_in  = '0;
    lwe      = 1'b0;
    laddr    = '0;
    ldata    = '0;
    for (int d = 0; d < NDUT; d++) begin
      last_pop[d] = 0;
      last_rd[d]  = '0;
    end

    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);

    // Preload every word so that any random address has defined contents.
    for (int i = 0; i < 1024; i++)
      step(1'b0, 1'b0, '0, 1'b1, 32'(i * 4), (i == 3) ? 32'h0010_0093 : $urandom);

    // Reset, then a single read of mem[3]
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h0000_000C, 1'b0, '0, '0);
    idle(6);

    // Back-to-back requests
    step(1'b0, 1'b1, 32'h0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h4, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h8, 1'b0, '0, '0);
    idle(10);

    // Continuous requests (throttles the W>0 responders)
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'(i * 4), 1'b0, '0, '0);
    idle(12);

    // Illegal addresses: misaligned, then out of range
    step(1'b0, 1'b1, 32'h0000_0006, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h0000_1000, 1'b0, '0, '0);
    idle(12);

    // Reset with requests in flight, then a read after release
    step(1'b0, 1'b1, 32'h0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 32'h4, 1'b0, '0, '0);
    idle(1);
    step(1'b1, 1'b1, 32'h8, 1'b0, '0, '0);
    idle(3);
    step(1'b0, 1'b1, 32'h0000_000C, 1'b0, '0, '0);
    idle(10);

    // Read/write collision on word 4
    step(1'b0, 1'b1, 32'h10, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h10, 32'hCAFE_F00D);
    idle(8);
    step(1'b0, 1'b1, 32'h10, 1'b0, '0, '0);
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rq  = ($urandom_range(0, 99) < 65);
      r   = $urandom_range(0, 19);
      if (r == 0)      a = {20'h0, $urandom_range(0, 1023) == 0 ? 10'd1 : 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      else if (r == 1) a = 32'h0000_1000 + 32'($urandom_range(0, 65535)) * 4;
      else             a = 32'($urandom_range(0, 1023)) * 4;
      rst = ($urandom_range(0, 199) == 0);
      we  = !rst && ($urandom_range(0, 99) < 20);
      la  = ($urandom_range(0, 9) == 0) ? 32'h0000_1000 + 32'($urandom_range(0, 4095))
                                        : 32'($urandom_range(0, 4095));
      ld  = $urandom;
      step(rst, rq, a, we, la, ld);
    end
    idle(20);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
